// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU.
//   - 3-bit op-code encodings, OP_ADD through OP_MUL
//   - FSM state encoding for the iterative multiply
//   - bit positions of the packed {V,N,C,Z} flag vector
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit and alu_seq.
//   master (control unit): drives start_i, x_i, y_i, op_i;
//                          observes busy_o, done_o, r_o and the flags
//   slave  (alu_seq)     : the reverse
// Signal names keep the ALU-side direction suffixes so they match the
// block's documented pin list.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic [2:0]       op_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] r_o;
  logic             fz_o;
  logic             fc_o;
  logic             fn_o;
  logic             fv_o;

  modport master (
    output start_i, x_i, y_i, op_i,
    input  busy_o, done_o, r_o, fz_o, fc_o, fn_o, fv_o
  );

  modport slave (
    input  start_i, x_i, y_i, op_i,
    output busy_o, done_o, r_o, fz_o, fc_o, fn_o, fv_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier datapath, one partial product per step.
// The whole module only exists when ALU_MUL_EN is defined.
//   clk, rst   : clock and synchronous active-high reset (counter only)
//   load       : capture a/b, clear accumulator and counter
//   step       : perform one shift-add iteration
//   a, b       : multiplicand / multiplier (WIDTH bits)
//   prod_next  : accumulator value including the current iteration
//   last       : current iteration is the final one (counter == WIDTH-1)
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Presenting the accumulator with this step's partial product folded in
  // lets the parent commit the result on the last iteration edge itself.
  assign prod_next = acc + (mplier[0] ? mcand : '0);
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      acc    <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake and Z/C/N/V flags.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : alu_seq_if slave (start_i, x_i, y_i, op_i in;
//           busy_o, done_o, r_o, fz_o, fc_o, fn_o, fv_o out)
// Single-cycle ops complete one edge after start_i. With ALU_MUL_EN
// defined, op 111 runs a WIDTH-cycle shift-add multiply (busy_o high);
// without it op 111 is a reserved no-op that still pulses done_o.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_seq_if.slave bus
);

  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   diff_p0;
  logic [WIDTH-1:0] res_p0;
  logic             c_p0;
  logic             v_p0;
  logic             wr_p0;

  logic [WIDTH-1:0] r_p1;
  logic [3:0]       flags_p1;
  logic             done_p1;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_V] = v;
    return f;
  endfunction

  // Stage p0: combinational single-cycle result from the live request
  always_comb begin
    sum_p0  = {1'b0, bus.x_i} + {1'b0, bus.y_i};
    diff_p0 = {1'b0, bus.x_i} - {1'b0, bus.y_i};
    res_p0  = '0;
    c_p0    = 1'b0;
    v_p0    = 1'b0;
    wr_p0   = 1'b1;
    case (bus.op_i)
      OP_ADD: begin
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = add_ovf(bus.x_i, bus.y_i, sum_p0[WIDTH-1:0]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow out.
        res_p0 = diff_p0[WIDTH-1:0];
        c_p0   = diff_p0[WIDTH];
        v_p0   = sub_ovf(bus.x_i, bus.y_i, diff_p0[WIDTH-1:0]);
      end
      OP_LDA: res_p0 = bus.y_i;
      OP_AND: res_p0 = bus.x_i & bus.y_i;
      OP_OR:  res_p0 = bus.x_i | bus.y_i;
      OP_XOR: res_p0 = bus.x_i ^ bus.y_i;
      OP_SHL: begin
        res_p0 = {bus.x_i[WIDTH-2:0], 1'b0};
        c_p0   = bus.x_i[WIDTH-1];
      end
      // Multiply result comes from the iterative path, or op is reserved
      // and leaves r_o/flags untouched.
      OP_MUL: wr_p0 = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  state_t             state;
  logic               busy_p1;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_load = (state == ST_IDLE) && bus.start_i && (bus.op_i == OP_MUL);
  assign mul_step = (state == ST_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (mul_load),
    .step      (mul_step),
    .a         (bus.x_i),
    .b         (bus.y_i),
    .prod_next (mul_prod),
    .last      (mul_last)
  );

  // Stage p1: registered result, flags and handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      r_p1     <= '0;
      flags_p1 <= '0;
    end else begin
      done_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.op_i == OP_MUL) begin
              state   <= ST_MUL;
              busy_p1 <= 1'b1;
            end else begin
              done_p1 <= 1'b1;
              if (wr_p0) begin
                r_p1     <= res_p0;
                flags_p1 <= pack_flags(res_p0, c_p0, v_p0);
              end
            end
          end
        end
        ST_MUL: begin
          // start_i is deliberately not looked at while multiplying.
          if (mul_last) begin
            r_p1     <= mul_prod[WIDTH-1:0];
            flags_p1 <= pack_flags(mul_prod[WIDTH-1:0],
                                   |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
            busy_p1  <= 1'b0;
            done_p1  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_p1;
`else
  // Stage p1: registered result, flags and handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_p1  <= 1'b0;
      r_p1     <= '0;
      flags_p1 <= '0;
    end else begin
      done_p1 <= bus.start_i;
      if (bus.start_i && wr_p0) begin
        r_p1     <= res_p0;
        flags_p1 <= pack_flags(res_p0, c_p0, v_p0);
      end
    end
  end

  assign bus.busy_o = 1'b0;
`endif

  assign bus.done_o = done_p1;
  assign bus.r_o    = r_p1;
  assign bus.fz_o   = flags_p1[FLAG_Z];
  assign bus.fc_o   = flags_p1[FLAG_C];
  assign bus.fn_o   = flags_p1[FLAG_N];
  assign bus.fv_o   = flags_p1[FLAG_V];

endmodule
